queue_scan_engine: RTL and testbench

Parametrised, pipelined scan engine for the pathfinding open-list RAM. It replaces the separate minimum-cost, free-slot and node-lookup scanners with one engine selected by `mode`. It issues one RAM read per cycle instead of one per three. It sits between the pathfinding controller and the open-list RAM read port, which has 1-cycle registered read latency.

---
 rtl/queue_scan_engine.sv | 218 +++++++++++++++++++++
 tb/tb_queue_scan_engine.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/queue_scan_engine.sv
// Pipelined open-list scan engine: one RAM read per cycle, with min-cost, free-slot and
// node-lookup searches selected by mode. RAM read data arrives one cycle after the address.
module queue_scan_engine #(
    parameter int unsigned DEPTH      = 100,
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned ID_W       = 16,
    parameter int unsigned COST_W     = 16,
    parameter int unsigned EMPTY_ID   = 0,
    parameter int unsigned REMOVED_ID = 800
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ID_W-1:0]   key_id,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [ID_W-1:0]   rd_id,
    input  logic [COST_W-1:0] rd_cost,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [ADDR_W-1:0] result_addr,
    output logic [ID_W-1:0]   result_id,
    output logic [COST_W-1:0] result_cost
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [1:0] MODE_MIN  = 2'b00;
    localparam logic [1:0] MODE_FREE = 2'b01;
    localparam logic [1:0] MODE_FIND = 2'b10;

    localparam logic [ID_W-1:0]   EMPTY_C   = ID_W'(EMPTY_ID);
    localparam logic [ID_W-1:0]   REMOVED_C = ID_W'(REMOVED_ID);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
    localparam logic [COST_W-1:0] COST_ONES = {COST_W{1'b1}};

    logic [1:0]        state_r, state_s;
    logic [1:0]        mode_r, mode_s;
    logic [ID_W-1:0]   key_r, key_s;
    logic              rd_en_r, rd_en_s;
    logic [ADDR_W-1:0] rd_addr_r, rd_addr_s;
    logic              eval_valid_r, eval_valid_s;
    logic [ADDR_W-1:0] eval_tag_r, eval_tag_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              found_r, found_s;
    logic [ADDR_W-1:0] res_addr_r, res_addr_s;
    logic [ID_W-1:0]   res_id_r, res_id_s;
    logic [COST_W-1:0] res_cost_r, res_cost_s;

    logic is_empty_s, is_removed_s, is_last_s;
    logic take_s, stop_s, hit_s, end_s;

    // Requests that can never match skip the scan entirely.
    function automatic logic direct_miss(input logic [1:0] m, input logic [ID_W-1:0] k);
        logic bad_key;
        bad_key = (k == EMPTY_C) || (k == REMOVED_C);
        return (m == 2'b11) || ((m == MODE_FIND) && bad_key);
    endfunction

    // Evaluate the entry whose data is on the read port this cycle.
    always_comb begin
        is_empty_s   = (rd_id == EMPTY_C);
        is_removed_s = (rd_id == REMOVED_C);
        is_last_s    = (eval_tag_r == LAST_ADDR);
        case (mode_r)
            MODE_MIN: begin
                take_s = !is_empty_s && !is_removed_s && (!found_r || (rd_cost < res_cost_r));
                stop_s = is_empty_s || is_last_s;
            end
            MODE_FREE: begin
                take_s = is_empty_s || is_removed_s;
                stop_s = take_s || is_last_s;
            end
            MODE_FIND: begin
                take_s = (rd_id == key_r);
                stop_s = take_s || is_empty_s || is_last_s;
            end
            default: begin
                take_s = 1'b0;
                stop_s = 1'b1;
            end
        endcase
        hit_s = eval_valid_r && take_s;
        end_s = eval_valid_r && stop_s;
    end

    // Next-state, issue pipeline and result capture.
    always_comb begin
        state_s      = state_r;
        mode_s       = mode_r;
        key_s        = key_r;
        rd_en_s      = rd_en_r;
        rd_addr_s    = rd_addr_r;
        eval_valid_s = 1'b0;
        eval_tag_s   = eval_tag_r;
        busy_s       = busy_r;
        done_s       = 1'b0;
        found_s      = found_r;
        res_addr_s   = res_addr_r;
        res_id_s     = res_id_r;
        res_cost_s   = res_cost_r;

        if (((state_r == ST_SCAN) || (state_r == ST_DRAIN)) && hit_s) begin
            found_s    = 1'b1;
            res_addr_s = eval_tag_r;
            res_id_s   = rd_id;
            res_cost_s = rd_cost;
        end else begin
            found_s = found_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    mode_s     = mode;
                    key_s      = key_id;
                    busy_s     = 1'b1;
                    found_s    = 1'b0;
                    res_addr_s = ZERO_ADDR;
                    res_id_s   = EMPTY_C;
                    res_cost_s = COST_ONES;
                    rd_addr_s  = ZERO_ADDR;
                    if (direct_miss(mode, key_id)) begin
                        state_s = ST_DRAIN;
                        rd_en_s = 1'b0;
                    end else begin
                        state_s = ST_SCAN;
                        rd_en_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (end_s) begin
                    // Any read already in flight is simply never evaluated.
                    state_s = ST_DONE;
                    rd_en_s = 1'b0;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                end else if (rd_addr_r == LAST_ADDR) begin
                    state_s      = ST_DRAIN;
                    rd_en_s      = 1'b0;
                    eval_valid_s = 1'b1;
                    eval_tag_s   = rd_addr_r;
                end else begin
                    rd_addr_s    = rd_addr_r + ADDR_W'(1'b1);
                    eval_valid_s = 1'b1;
                    eval_tag_s   = rd_addr_r;
                end
            end
            ST_DRAIN: begin
                state_s = ST_DONE;
                rd_en_s = 1'b0;
                busy_s  = 1'b0;
                done_s  = 1'b1;
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                rd_en_s = 1'b0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // Register state and every output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            mode_r       <= 2'b00;
            key_r        <= {ID_W{1'b0}};
            rd_en_r      <= 1'b0;
            rd_addr_r    <= ZERO_ADDR;
            eval_valid_r <= 1'b0;
            eval_tag_r   <= ZERO_ADDR;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            found_r      <= 1'b0;
            res_addr_r   <= ZERO_ADDR;
            res_id_r     <= EMPTY_C;
            res_cost_r   <= COST_ONES;
        end else begin
            state_r      <= state_s;
            mode_r       <= mode_s;
            key_r        <= key_s;
            rd_en_r      <= rd_en_s;
            rd_addr_r    <= rd_addr_s;
            eval_valid_r <= eval_valid_s;
            eval_tag_r   <= eval_tag_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            found_r      <= found_s;
            res_addr_r   <= res_addr_s;
            res_id_r     <= res_id_s;
            res_cost_r   <= res_cost_s;
        end
    end

    assign rd_en       = rd_en_r;
    assign rd_addr     = rd_addr_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign found       = found_r;
    assign result_addr = res_addr_r;
    assign result_id   = res_id_r;
    assign result_cost = res_cost_r;

endmodule

// File: tb/tb_queue_scan_engine.sv
// Scoreboard bench for queue_scan_engine: default instance (DEPTH=100) and a narrow
// instance (DEPTH=16, 8-bit ids, 12-bit costs), each behind its own RAM model.
module tb_queue_scan_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start_a, start_b;
    logic [1:0]  mode_in;
    logic [15:0] key_in;

    logic        rd_en_a, busy_a, done_a, found_a;
    logic [6:0]  rd_addr_a, res_addr_a;
    logic [15:0] rd_id_a, rd_cost_a, res_id_a, res_cost_a;

    logic        rd_en_b, busy_b, done_b, found_b;
    logic [3:0]  rd_addr_b, res_addr_b;
    logic [7:0]  rd_id_b, res_id_b;
    logic [11:0] rd_cost_b, res_cost_b;

    queue_scan_engine dut_a (
        .clk(clk), .reset(reset), .start(start_a), .mode(mode_in), .key_id(key_in),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_id(rd_id_a), .rd_cost(rd_cost_a),
        .busy(busy_a), .done(done_a), .found(found_a), .result_addr(res_addr_a),
        .result_id(res_id_a), .result_cost(res_cost_a)
    );

    queue_scan_engine #(.DEPTH(16), .ADDR_W(4), .ID_W(8), .COST_W(12), .EMPTY_ID(0), .REMOVED_ID(200)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .mode(mode_in), .key_id(key_in[7:0]),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_id(rd_id_b), .rd_cost(rd_cost_b),
        .busy(busy_b), .done(done_b), .found(found_b), .result_addr(res_addr_b),
        .result_id(res_id_b), .result_cost(res_cost_b)
    );

    logic [15:0] mem_id [0:99];
    logic [15:0] mem_cost [0:99];

    // Open-list RAMs with one-cycle registered read.
    always @(posedge clk) begin
        if (rd_en_a && (rd_addr_a < 7'd100)) begin
            rd_id_a   <= mem_id[rd_addr_a];
            rd_cost_a <= mem_cost[rd_addr_a];
        end
        if (rd_en_b) begin
            rd_id_b   <= mem_id[rd_addr_b][7:0];
            rd_cost_b <= mem_cost[rd_addr_b][11:0];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        dsel;
    int          depth_m, rd_addr_m, res_addr_m;
    logic        done_m, busy_m, found_m, rd_en_m;
    logic [15:0] res_id_m, res_cost_m;

    always_comb begin
        if (dsel) begin
            depth_m = 16; done_m = done_b; busy_m = busy_b; found_m = found_b; rd_en_m = rd_en_b;
            rd_addr_m = int'(rd_addr_b); res_addr_m = int'(res_addr_b);
            res_id_m = {8'd0, res_id_b}; res_cost_m = {4'd0, res_cost_b};
        end else begin
            depth_m = 100; done_m = done_a; busy_m = busy_a; found_m = found_a; rd_en_m = rd_en_a;
            rd_addr_m = int'(rd_addr_a); res_addr_m = int'(res_addr_a);
            res_id_m = res_id_a; res_cost_m = res_cost_a;
        end
    end

    typedef struct {
        logic        f;
        int          addr;
        logic [15:0] id;
        logic [15:0] cost;
        int          done_cyc;
        int          reads;
    } exp_t;

    exp_t exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

    task automatic check(input string name, input longint act, input longint expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: find the terminating entry, then pick the answer from the scanned range.
    function automatic exp_t model(input logic [1:0] m, input logic [15:0] key);
        exp_t e;
        int depth, stop_at, last_cand;
        bit stopped, any;
        logic [15:0] removed, ones, best;
        depth   = dsel ? 16 : 100;
        removed = dsel ? 16'd200 : 16'd800;
        ones    = dsel ? 16'h0FFF : 16'hFFFF;
        e.f = 1'b0; e.addr = 0; e.id = 16'd0; e.cost = ones; e.done_cyc = 1; e.reads = 0;
        if (m == 2'd3 || (m == 2'd2 && (key == 16'd0 || key == removed))) return e;
        stopped = 1'b0;
        stop_at = depth - 1;
        for (int i = 0; i < depth; i++) begin
            if (!stopped && ((m == 2'd0 && mem_id[i] == 16'd0) ||
                             (m == 2'd1 && (mem_id[i] == 16'd0 || mem_id[i] == removed)) ||
                             (m == 2'd2 && (mem_id[i] == key || mem_id[i] == 16'd0)))) begin
                stopped = 1'b1;
                stop_at = i;
            end
        end
        if ((m == 2'd1 && stopped) || (m == 2'd2 && stopped && mem_id[stop_at] == key)) begin
            e.f = 1'b1; e.addr = stop_at; e.id = mem_id[stop_at]; e.cost = mem_cost[stop_at];
        end
        if (m == 2'd0) begin
            last_cand = stopped ? stop_at - 1 : depth - 1;
            best = ones;
            any = 1'b0;
            for (int i = 0; i <= last_cand; i++)
                if (mem_id[i] != removed) begin
                    any = 1'b1;
                    if (mem_cost[i] < best) best = mem_cost[i];
                end
            for (int i = last_cand; i >= 0; i--)
                if (any && mem_id[i] != removed && mem_cost[i] == best) begin
                    e.f = 1'b1; e.addr = i; e.id = mem_id[i]; e.cost = mem_cost[i];
                end
        end
        e.done_cyc = stop_at + 2;
        e.reads = (stop_at + 2 > depth) ? depth : stop_at + 2;
        return e;
    endfunction

    task automatic fill(input int empty_pos, input int p_rem);
        logic [15:0] removed, mask;
        removed = dsel ? 16'd200 : 16'd800;
        mask    = dsel ? 16'h0FFF : 16'hFFFF;
        for (int i = 0; i < 100; i++) begin
            if (i == empty_pos) mem_id[i] = 16'd0;
            else if ($urandom_range(0, 99) < p_rem) mem_id[i] = removed;
            else mem_id[i] = 16'($urandom_range(1, dsel ? 199 : 700));
            case ($urandom_range(0, 3))
                0: mem_cost[i] = mask;
                3: mem_cost[i] = 16'($urandom) & mask;
                default: mem_cost[i] = 16'($urandom_range(0, 15));
            endcase
        end
    endtask

    task automatic run_scan(input logic [1:0] m, input logic [15:0] k, input bit hold);
        exp_t e;
        int t;
        e = model(m, k);
        @(negedge clk);
        mode_in = m;
        key_in  = k;
        if (dsel) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        e.done_cyc += cyc;
        exp_q.push_back(e);
        if (!hold) begin start_a = 1'b0; start_b = 1'b0; end
        t = 0;
        while (!done_m && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_tests++; n_fail++;
            $display("FAIL done_timeout: got no done within 200 cycles, expected one (mode %0d)", m);
            exp_q.delete();
        end
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic check_reset();
        check("rst_busy_a", busy_a, 0);       check("rst_done_a", done_a, 0);
        check("rst_found_a", found_a, 0);     check("rst_rd_en_a", rd_en_a, 0);
        check("rst_rd_addr_a", rd_addr_a, 0); check("rst_res_addr_a", res_addr_a, 0);
        check("rst_res_id_a", res_id_a, 0);   check("rst_res_cost_a", res_cost_a, 16'hFFFF);
        check("rst_busy_b", busy_b, 0);       check("rst_found_b", found_b, 0);
        check("rst_res_cost_b", res_cost_b, 12'hFFF);
    endtask

    // Monitor: checks every done against the oldest expectation and audits the read stream.
    initial begin
        int rd_cnt = 0;
        bit seq_bad = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                rd_cnt = 0;
                seq_bad = 1'b0;
            end else begin
                if (rd_en_m) begin
                    if (rd_addr_m != rd_cnt || rd_cnt >= depth_m) seq_bad = 1'b1;
                    rd_cnt++;
                end
                if (done_m) begin
                    done_cnt++;
                    if (exp_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_done: got done with nothing pending, expected no done");
                    end else begin
                        e = exp_q.pop_front();
                        check("found", found_m, e.f);
                        check("result_addr", res_addr_m, e.addr);
                        check("result_id", res_id_m, e.id);
                        check("result_cost", res_cost_m, e.cost);
                        check("done_cycle", cyc, e.done_cyc);
                        check("read_count", rd_cnt, e.reads);
                        check("read_sequence_bad", seq_bad, 0);
                        check("busy_at_done", busy_m, 0);
                    end
                    rd_cnt = 0;
                    seq_bad = 1'b0;
                end
            end
        end
    end

    initial begin
        int d0;
        logic [1:0]  m;
        logic [15:0] k;
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0; dsel = 1'b0;
        mode_in = 2'b00; key_in = 16'd0;
        fill(-1, 0);
        repeat (3) @(negedge clk);
        check_reset();
        reset = 1'b0;

        // Tie on cost 12 plus a cheaper tombstone.
        mem_id[0] = 16'd5; mem_id[1] = 16'd7; mem_id[2] = 16'd800; mem_id[3] = 16'd9; mem_id[4] = 16'd0;
        mem_cost[0] = 16'd40; mem_cost[1] = 16'd12; mem_cost[2] = 16'd3; mem_cost[3] = 16'd12;
        run_scan(2'd0, 16'd0, 1'b0);
        mem_id[0] = 16'd5; mem_id[1] = 16'd800; mem_id[2] = 16'd9; mem_id[3] = 16'd0;
        run_scan(2'd1, 16'd0, 1'b0);
        run_scan(2'd2, 16'd9, 1'b0);
        run_scan(2'd2, 16'd42, 1'b0);
        run_scan(2'd2, 16'd0, 1'b0);
        run_scan(2'd2, 16'd800, 1'b0);
        run_scan(2'd3, 16'd5, 1'b0);
        mem_id[0] = 16'd3; mem_id[1] = 16'd4; mem_id[2] = 16'd0;
        mem_cost[0] = 16'hFFFF; mem_cost[1] = 16'hFFFF;
        run_scan(2'd0, 16'd0, 1'b0);

        fill(-1, 0);
        run_scan(2'd1, 16'd0, 1'b0);
        run_scan(2'd0, 16'd0, 1'b0);
        run_scan(2'd2, 16'd750, 1'b0);
        run_scan(2'd2, mem_id[99], 1'b1);
        fill(30, 10);
        run_scan(2'd0, 16'd0, 1'b1);

        for (int it = 0; it < 24; it++) begin
            fill($urandom_range(0, 130), 20);
            m = 2'($urandom_range(0, 3));
            k = ($urandom_range(0, 1) == 0) ? mem_id[$urandom_range(0, 99)] : 16'($urandom_range(0, 1000));
            run_scan(m, k, 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a full-length scan.
        fill(-1, 0);
        @(negedge clk);
        mode_in = 2'd0; start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        repeat (10) @(negedge clk);
        d0 = done_cnt;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset();
        repeat (120) @(negedge clk);
        check("done_after_reset", done_cnt - d0, 0);
        run_scan(2'd1, 16'd0, 1'b0);

        dsel = 1'b1;
        for (int it = 0; it < 5; it++) begin
            fill(-1, 0);
            run_scan(2'd0, 16'd0, 1'b0);
        end
        for (int it = 0; it < 8; it++) begin
            fill($urandom_range(0, 20), 15);
            m = 2'($urandom_range(0, 3));
            k = ($urandom_range(0, 1) == 0) ? mem_id[$urandom_range(0, 15)] : 16'($urandom_range(1, 255));
            run_scan(m, k, 1'b0);
        end

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
